// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps a 4-LED active-low bank through fill/walk/user/blink patterns; LED_SEQ_REVERSE_EN adds a reverse-direction input
module led_pattern_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pause,
  input  logic       step_req,
  input  logic [1:0] mode,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
`ifdef LED_SEQ_REVERSE_EN
  input  logic       reverse,
`endif
  output logic       wr_ready,
  output logic       tick,
  output logic [2:0] step_idx,
  output logic [3:0] LEDs
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [31:0] FILL = 32'hFEC808CE;
  localparam logic [31:0] WALK = 32'h7BDE7BDE;
  localparam logic [31:0] BLINK = 32'hF0F0F0F0;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [1:0] mode_q;
  logic [3:0] tbl [DEPTH];
  logic [3:0] pat;
  logic last, adv, rev;
`ifdef LED_SEQ_REVERSE_EN
  assign rev = reverse;
`else
  assign rev = 1'b0;
`endif
  assign wr_ready = state != RUN;
  assign last = presc == PW'(TICK_DIV - 1);
  assign adv = (state == RUN && !pause && last) || (state == HOLD && pause && step_req);
  always_comb
    pat = mode_q == 2'd0 ? FILL[{step_idx, 2'b00} +: 4] :
          mode_q == 2'd1 ? WALK[{step_idx, 2'b00} +: 4] :
          mode_q == 2'd2 ? tbl[step_idx] : BLINK[{step_idx, 2'b00} +: 4];
  // while enabled the next state depends only on pause; the index and mode advance together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      step_idx <= '0;
      tick <= 1'b0;
      LEDs <= 4'hF;
      mode_q <= 2'd0;
    end else if (!enable) begin
      state <= IDLE;
      presc <= '0;
      step_idx <= '0;
      tick <= 1'b0;
      LEDs <= 4'hF;
    end else begin
      state <= pause ? HOLD : RUN;
      tick <= state == RUN && !pause && last;
      LEDs <= state == IDLE ? 4'hF : pat;
      if (state == RUN && !pause) presc <= last ? '0 : presc + 1'b1;
      if (state == IDLE || adv) mode_q <= mode;
      if (adv) step_idx <= mode != mode_q ? 3'd0 : rev ? step_idx - 3'd1 : step_idx + 3'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 4'hF;
    end else if (wr_en && wr_ready) begin
      tbl[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed scenarios plus randomized run against a behavioural model
module tb_led_pattern_sequencer;
  logic clk = 0, rst = 0, enable = 0, pause = 0, step_req = 0, wr_en = 0;
  logic [1:0] mode = 0;
  logic [2:0] wr_addr = 0;
  logic [3:0] wr_data = 0;
`ifdef LED_SEQ_REVERSE_EN
  logic reverse = 0;
`endif
  logic wr_ready, tick;
  logic [2:0] step_idx;
  logic [3:0] LEDs;
  int tests = 0, fails = 0;
  bit cmp_on = 0;
  int fill_t[8] = '{14, 12, 8, 0, 8, 12, 14, 15};
  int walk_t[4] = '{14, 13, 11, 7};
  int exp1[9] = '{14, 12, 8, 0, 8, 12, 14, 15, 14};
  int mtbl[8];
  int m_ph = 0, m_cnt = 0, m_idx = 0, m_mq = 0, m_led = 15, m_tk = 0;
  time t_prev;

  led_pattern_sequencer #(.TICK_DIV(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pause(pause), .step_req(step_req),
    .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef LED_SEQ_REVERSE_EN
    .reverse(reverse),
`endif
    .wr_ready(wr_ready), .tick(tick), .step_idx(step_idx), .LEDs(LEDs)
  );

  always #5 clk = ~clk;

  function automatic int pat(input int m, input int i);
    if (m == 0) return fill_t[i];
    if (m == 1) return walk_t[i % 4];
    if (m == 2) return mtbl[i];
    return (i % 2 == 1) ? 15 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model phases: 0 idle, 1 running, 2 held
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_idx = 0; m_mq = 0; m_led = 15; m_tk = 0;
      for (int i = 0; i < 8; i++) mtbl[i] = 15;
    end else begin
      int shown, rv;
      bit step;
      shown = (m_ph == 0) ? 15 : pat(m_mq, m_idx);
      step = enable && ((m_ph == 1 && !pause && m_cnt == 3) || (m_ph == 2 && pause && step_req));
      rv = 0;
`ifdef LED_SEQ_REVERSE_EN
      rv = reverse;
`endif
      if (wr_en && m_ph != 1) mtbl[wr_addr] = wr_data;
      if (!enable) begin
        m_ph = 0; m_cnt = 0; m_idx = 0; m_tk = 0; m_led = 15;
      end else begin
        m_led = shown;
        m_tk = (m_ph == 1 && !pause && m_cnt == 3) ? 1 : 0;
        if (m_ph == 1 && !pause) m_cnt = (m_cnt + 1) % 4;
        if (step) begin
          m_idx = (mode != m_mq) ? 0 : (rv != 0) ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
          m_mq = mode;
        end else if (m_ph == 0) m_mq = mode;
        m_ph = pause ? 2 : 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("model_idx", step_idx, m_idx);
      chk("model_leds", LEDs, m_led);
      chk("model_tick", tick, m_tk);
      chk("model_wr_ready", wr_ready, m_ph != 1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    do begin cyc(1); n++; end while (!tick && n < 20);
    if (!tick) begin
      tests++; fails++;
      $display("FAIL %s: no tick within %0d cycles", nm, n);
    end
  endtask

  task automatic pulse_step();
    step_req = 1; cyc(1); step_req = 0;
  endtask

  initial begin
    rst = 1;
    cyc(2);
    rst = 0;
    cmp_on = 1;
    chk("rst_leds", LEDs, 15);
    chk("rst_idx", step_idx, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wr_ready", wr_ready, 1);
    // fill pattern with a tick every 4 clocks
    enable = 1; mode = 0;
    cyc(2);
    chk("fill_first", LEDs, exp1[0]);
    for (int k = 1; k <= 8; k++) begin
      wait_tick("fill_tick");
      if (k > 1) chk("tick_period", int'(($time - t_prev) / 10), 4);
      t_prev = $time;
      chk("fill_idx", step_idx, k % 8);
      cyc(1);
      chk("fill_leds", LEDs, exp1[k]);
    end
    // pause at index 2, then single steps
    wait_tick("pre_pause");
    wait_tick("pre_pause");
    chk("pause_idx", step_idx, 2);
    pause = 1;
    begin
      int seen = 0;
      repeat (20) begin cyc(1); if (tick) seen++; end
      chk("hold_no_tick", seen, 0);
    end
    chk("hold_idx", step_idx, 2);
    chk("hold_leds", LEDs, 8);
    pulse_step();
    chk("step1_idx", step_idx, 3);
    cyc(1);
    chk("step1_leds", LEDs, 0);
    pulse_step();
    chk("step2_idx", step_idx, 4);
    cyc(1);
    chk("step2_leds", LEDs, 8);
    chk("step_no_tick", tick, 0);
    // user table load in HOLD
    chk("hold_wr_ready", wr_ready, 1);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 4'(i + 1); cyc(1);
    end
    wr_en = 0;
    mode = 2;
    pulse_step();
    chk("user_idx_reset", step_idx, 0);
    cyc(1);
    chk("user_leds0", LEDs, 1);
    wr_en = 1; wr_addr = 0; wr_data = 9; cyc(1); wr_en = 0;
    cyc(1);
    chk("user_live_write", LEDs, 9);
    pause = 0; cyc(1);
    chk("run_wr_ready", wr_ready, 0);
    wr_en = 1; wr_addr = 1; wr_data = 10; cyc(1); wr_en = 0;
    pause = 1; cyc(1);
    pulse_step();
    chk("user_idx1", step_idx, 1);
    cyc(1);
    chk("dropped_write", LEDs, 2);
    // mode change between sample points
    mode = 0; pause = 0;
    wait_tick("mode_fill");
    chk("mode_fill_idx", step_idx, 0);
    cyc(2);
    chk("mode_fill_leds", LEDs, 14);
    mode = 3;
    cyc(1);
    chk("mode_pending_leds", LEDs, 14);
    wait_tick("mode_blink");
    chk("blink_idx", step_idx, 0);
    cyc(1);
    chk("blink_leds0", LEDs, 0);
    wait_tick("blink_next");
    chk("blink_idx1", step_idx, 1);
    cyc(1);
    chk("blink_leds1", LEDs, 15);
    // disable and async reset mid-step
    cyc(1);
    enable = 0; cyc(1);
    chk("dis_idx", step_idx, 0);
    chk("dis_leds", LEDs, 15);
    chk("dis_wr_ready", wr_ready, 1);
    enable = 1; mode = 0;
    wait_tick("re_run");
    wait_tick("re_run");
    cyc(1);
    chk("pre_rst_idx", step_idx, 2);
    #2 rst = 1;
    #1;
    chk("arst_leds", LEDs, 15);
    chk("arst_idx", step_idx, 0);
    chk("arst_tick", tick, 0);
    chk("arst_wr_ready", wr_ready, 1);
    @(posedge clk); #1 rst = 0;
`ifdef LED_SEQ_REVERSE_EN
    reverse = 1; mode = 0; pause = 0; enable = 1;
    wait_tick("rev1");
    chk("rev_idx7", step_idx, 7);
    cyc(1);
    chk("rev_leds7", LEDs, 15);
    wait_tick("rev2");
    chk("rev_idx6", step_idx, 6);
    cyc(1);
    chk("rev_leds6", LEDs, 14);
    wait_tick("rev3");
    chk("rev_idx5", step_idx, 5);
    cyc(1);
    chk("rev_leds5", LEDs, 12);
    reverse = 0;
`endif
    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 2500; c++) begin
      enable = enable ? ($urandom_range(63) != 0) : ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) pause = !pause;
      if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
      step_req = $urandom_range(3) == 0;
      wr_en = $urandom_range(3) == 0;
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
`ifdef LED_SEQ_REVERSE_EN
      if ($urandom_range(15) == 0) reverse = !reverse;
`endif
      if ($urandom_range(399) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
      @(posedge clk); #1;
    end
    step_req = 0; wr_en = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
